// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a carry flag, zero flag,
// serial (1 bit per cycle) shifts and a start/busy/done handshake.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   reset   in   1      synchronous, active-high reset
//   start   in   1      launch an operation; sampled only when idle
//   aluc    in   4      operation code, latched at accepted start
//   a       in   WIDTH  operand A, latched at accepted start
//   b       in   WIDTH  operand B, latched at accepted start; b[SW-1:0] = shift amount
//   cy_in   in   1      external carry-in (EXT_CY=1 only), sampled at start
//   z       out  WIDTH  result register
//   cy_out  out  1      carry flag register
//   zf      out  1      zero flag register, (z == 0)
//   busy    out  1      operation in progress
//   done    out  1      one-cycle pulse when z/cy_out/zf hold the new result
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter int EXT_CY = 0,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic [WIDTH-1:0] z,
    output logic             cy_out,
    output logic             zf,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SW:0]      ONE_C  = {{SW{1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [3:0]       aluc_r, aluc_s;
    // a_r doubles as the working shift register during SHIFT
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic             ci_r, ci_s;
    // Loaded with amount+1: the final SHIFT cycle commits carry and done
    logic [SW:0]      cnt_r, cnt_s;
    // Last bit shifted out, committed to cy_out when the shift completes
    logic             sc_r, sc_s;
    logic [WIDTH-1:0] z_r, z_s;
    logic             cy_r, cy_s;
    logic             zf_r, zf_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic [WIDTH-1:0] op2_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;

    // Shared adder for ADD, ADC and SUB (a + ~b + 1)
    always_comb begin
        op2_s = b_r;
        cin_s = 1'b0;
        case (aluc_r)
            4'b0101: cin_s = ci_r;
            4'b1101: begin
                op2_s = ~b_r;
                cin_s = 1'b1;
            end
            default: cin_s = 1'b0;
        endcase
        sum_s = {1'b0, a_r} + {1'b0, op2_s} + {{WIDTH{1'b0}}, cin_s};
    end

    // Next-state, datapath and output computation
    always_comb begin
        state_s = state_r;
        aluc_s  = aluc_r;
        a_s     = a_r;
        b_s     = b_r;
        ci_s    = ci_r;
        cnt_s   = cnt_r;
        sc_s    = sc_r;
        z_s     = z_r;
        cy_s    = cy_r;
        zf_s    = zf_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    aluc_s = aluc;
                    a_s    = a;
                    b_s    = b;
                    ci_s   = (EXT_CY != 0) ? cy_in : cy_r;
                    sc_s   = cy_r;
                    busy_s = 1'b1;
                    // A zero shift amount falls through to the single-cycle path
                    if ((aluc[3:1] == 3'b111) && (b[SW-1:0] != {SW{1'b0}})) begin
                        state_s = ST_SHIFT;
                        cnt_s   = {1'b0, b[SW-1:0]} + ONE_C;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                case (aluc_r)
                    4'b0000: z_s = a_r;
                    4'b0001: z_s = b_r;
                    4'b0010: z_s = ~a_r;
                    4'b0011: z_s = ~b_r;
                    4'b0100: {cy_s, z_s} = sum_s;
                    4'b0101: {cy_s, z_s} = sum_s;
                    4'b0110: z_s = a_r | b_r;
                    4'b0111: z_s = a_r & b_r;
                    4'b1000: z_s = ZERO_W;
                    4'b1001: z_s = ONE_W;
                    4'b1010: z_s = ~ZERO_W;
                    4'b1011: cy_s = 1'b0;
                    4'b1100: cy_s = 1'b1;
                    4'b1101: {cy_s, z_s} = sum_s;
                    // Only zero-amount shifts reach here: pass a through
                    4'b1110: z_s = a_r;
                    4'b1111: z_s = a_r;
                    default: z_s = z_r;
                endcase
                zf_s    = (z_s == ZERO_W);
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt_r == ONE_C) begin
                    cy_s    = sc_r;
                    zf_s    = (z_r == ZERO_W);
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    if (aluc_r[0] == 1'b0) begin
                        sc_s = a_r[WIDTH-1];
                        a_s  = {a_r[WIDTH-2:0], 1'b0};
                    end else begin
                        sc_s = a_r[0];
                        a_s  = {1'b0, a_r[WIDTH-1:1]};
                    end
                    z_s     = a_s;
                    zf_s    = (a_s == ZERO_W);
                    cnt_s   = cnt_r - ONE_C;
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial shift
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            aluc_r  <= 4'b0000;
            a_r     <= ZERO_W;
            b_r     <= ZERO_W;
            ci_r    <= 1'b0;
            cnt_r   <= {(SW+1){1'b0}};
            sc_r    <= 1'b0;
            z_r     <= ZERO_W;
            cy_r    <= 1'b0;
            zf_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            aluc_r  <= aluc_s;
            a_r     <= a_s;
            b_r     <= b_s;
            ci_r    <= ci_s;
            cnt_r   <= cnt_s;
            sc_r    <= sc_s;
            z_r     <= z_s;
            cy_r    <= cy_s;
            zf_r    <= zf_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign z      = z_r;
    assign cy_out = cy_r;
    assign zf     = zf_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16, EXT_CY=0).
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  aluc;
    logic [15:0] a;
    logic [15:0] b;
    logic        cy_in;
    logic [15:0] z;
    logic        cy_out;
    logic        zf;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int lat;
    int done_seen;

    alu_seq #(.WIDTH(16), .EXT_CY(0)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .aluc   (aluc),
        .a      (a),
        .b      (b),
        .cy_in  (cy_in),
        .z      (z),
        .cy_out (cy_out),
        .zf     (zf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op; keep start high with a different opcode for 'hold'
    // cycles after acceptance; return edges from acceptance to done.
    task automatic run_op(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                          input int hold, output int n);
        @(negedge clk);
        start = 1'b1;
        aluc  = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        check("busy_at_accept", {31'd0, busy}, 32'd1);
        if (hold > 0) begin
            aluc = 4'b1000;
            a    = 16'h0000;
            b    = 16'h0000;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n >= hold) start = 1'b0;
            if (done) break;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        aluc  = 4'b0000;
        a     = 16'h0000;
        b     = 16'h0000;
        cy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_z", {16'd0, z}, 32'h0000);
        check("rst_cy", {31'd0, cy_out}, 32'd0);
        check("rst_zf", {31'd0, zf}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD with wrap, then ADC consuming the carry
        run_op(4'b0100, 16'hFFFF, 16'h0001, 0, lat);
        check("add_lat", lat, 1);
        check("add_z", {16'd0, z}, 32'h0000);
        check("add_cy", {31'd0, cy_out}, 32'd1);
        check("add_zf", {31'd0, zf}, 32'd1);
        @(posedge clk);
        #1;
        check("add_done_pulse", {31'd0, done}, 32'd0);
        check("add_busy_after", {31'd0, busy}, 32'd0);

        run_op(4'b0101, 16'h0001, 16'h0001, 0, lat);
        check("adc_z", {16'd0, z}, 32'h0003);
        check("adc_cy", {31'd0, cy_out}, 32'd0);
        check("adc_zf", {31'd0, zf}, 32'd0);

        // SUB with and without borrow
        run_op(4'b1101, 16'h0005, 16'h0007, 0, lat);
        check("sub1_z", {16'd0, z}, 32'hFFFE);
        check("sub1_cy", {31'd0, cy_out}, 32'd0);
        run_op(4'b1101, 16'h0007, 16'h0005, 0, lat);
        check("sub2_z", {16'd0, z}, 32'h0002);
        check("sub2_cy", {31'd0, cy_out}, 32'd1);
        check("sub2_zf", {31'd0, zf}, 32'd0);

        // Logic / constant ops
        run_op(4'b0110, 16'hF0F0, 16'h0F0F, 0, lat);
        check("or_z", {16'd0, z}, 32'hFFFF);
        run_op(4'b0111, 16'hF0F0, 16'h0FF0, 0, lat);
        check("and_z", {16'd0, z}, 32'h00F0);
        run_op(4'b0010, 16'h00FF, 16'h1234, 0, lat);
        check("nota_z", {16'd0, z}, 32'hFF00);
        run_op(4'b0011, 16'h0000, 16'h1234, 0, lat);
        check("notb_z", {16'd0, z}, 32'hEDCB);
        run_op(4'b0000, 16'h5555, 16'h1234, 0, lat);
        check("pass_a_z", {16'd0, z}, 32'h5555);
        run_op(4'b0001, 16'h5555, 16'hAAAA, 0, lat);
        check("pass_b_z", {16'd0, z}, 32'hAAAA);
        run_op(4'b1010, 16'h0000, 16'h0000, 0, lat);
        check("ones_z", {16'd0, z}, 32'hFFFF);
        run_op(4'b1000, 16'h1111, 16'h2222, 0, lat);
        check("zero_z", {16'd0, z}, 32'h0000);
        check("zero_zf", {31'd0, zf}, 32'd1);
        check("zero_cy_kept", {31'd0, cy_out}, 32'd1);

        // Serial shifts
        run_op(4'b1110, 16'h8001, 16'h0004, 0, lat);
        check("shl_lat", lat, 5);
        check("shl_z", {16'd0, z}, 32'h0010);
        check("shl_cy", {31'd0, cy_out}, 32'd0);
        run_op(4'b1111, 16'h0001, 16'h0001, 0, lat);
        check("shr_lat", lat, 2);
        check("shr_z", {16'd0, z}, 32'h0000);
        check("shr_cy", {31'd0, cy_out}, 32'd1);
        check("shr_zf", {31'd0, zf}, 32'd1);

        // Start held high with another opcode while busy is ignored
        run_op(4'b1110, 16'h00FF, 16'h000F, 3, lat);
        check("ign_lat", lat, 16);
        check("ign_z", {16'd0, z}, 32'h8000);
        check("ign_cy", {31'd0, cy_out}, 32'd1);
        @(posedge clk);
        #1;
        check("ign_no_queue", {31'd0, busy}, 32'd0);

        // Reset in the middle of a 10-cycle shift
        @(negedge clk);
        start = 1'b1;
        aluc  = 4'b1110;
        a     = 16'h0003;
        b     = 16'h000A;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_z", {16'd0, z}, 32'h0000);
        check("mid_rst_cy", {31'd0, cy_out}, 32'd0);
        check("mid_rst_zf", {31'd0, zf}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        run_op(4'b1001, 16'h1234, 16'h5678, 0, lat);
        check("one_z", {16'd0, z}, 32'h0001);
        check("one_zf", {31'd0, zf}, 32'd0);

        // Carry set/clear leave z untouched
        run_op(4'b1100, 16'h1234, 16'h0000, 0, lat);
        check("scf_z", {16'd0, z}, 32'h0001);
        check("scf_cy", {31'd0, cy_out}, 32'd1);
        run_op(4'b1011, 16'h1234, 16'h0000, 0, lat);
        check("ccf_z", {16'd0, z}, 32'h0001);
        check("ccf_cy", {31'd0, cy_out}, 32'd0);
        check("ccf_zf", {31'd0, zf}, 32'd0);

        // Zero-amount shifts: z=a, carry kept, single-cycle latency
        run_op(4'b1110, 16'hA5A5, 16'h0000, 0, lat);
        check("shl0_lat", lat, 1);
        check("shl0_z", {16'd0, z}, 32'hA5A5);
        check("shl0_cy", {31'd0, cy_out}, 32'd0);
        run_op(4'b1100, 16'h0000, 16'h0000, 0, lat);
        run_op(4'b1111, 16'h0F0F, 16'h0010, 0, lat);
        check("shr0_lat", lat, 1);
        check("shr0_z", {16'd0, z}, 32'h0F0F);
        check("shr0_cy", {31'd0, cy_out}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the 16-bit combinational ALU.
- Keeps the same 4-bit operation encoding. Adds a carry flag register so ADC can chain across operations.
- Adds subtract, multi-cycle serial shifts, a zero flag and a start/busy/done handshake.
- Sits between the register file operand buses and the writeback path of the datapath.

Parameters:
- WIDTH, 16: operand/result width. Must be a power of two, >= 4.
- EXT_CY, 0: carry-in source for ADC. 0 = internal cy flag register, 1 = cy_in port.
- SW, $clog2(WIDTH): shift-amount width, derived. Not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- aluc  in  4  operation code, latched at accepted start
- a  in  WIDTH  operand A, latched at accepted start
- b  in  WIDTH  operand B, latched at accepted start; b[SW-1:0] = shift amount for shifts
- cy_in  in  1  external carry-in, used only when EXT_CY=1, sampled at start
- z  out  WIDTH  result register
- cy_out  out  1  carry flag register
- zf  out  1  zero flag register: (z == 0), updated whenever z is written
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when z/cy_out/zf hold the new result

Behaviour:
- One clock. Reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- Reset values: z=0, cy_out=0, zf=1, busy=0, done=0, FSM=IDLE. Reset has priority over everything, including mid-shift; a partial shift result is discarded.
- FSM states:
  - IDLE --start--> EXEC (single-cycle op) or SHIFT (aluc 1110/1111 with amount > 0).
  - EXEC --> IDLE, raising done.
  - SHIFT --count==1--> IDLE, raising done; otherwise stays in SHIFT and decrements count.
- Accepted start: operands, aluc and carry-in are latched on that edge, so input changes afterwards have no effect.
- start while busy=1 is ignored; no queueing.
- Latency:
  - Single-cycle ops: start accepted at edge N; z/flags/done visible after edge N+1. busy is high for one cycle.
  - Shift by k>0: done after edge N+k+1; busy is high k+1 cycles. Each SHIFT cycle moves exactly 1 bit.
  - Shift by k=0 behaves as a single-cycle op: z=a, cy unchanged.
- Op codes. Carry is unchanged unless listed; z unchanged for 1011/1100.
  - 0000 z=a
  - 0001 z=b
  - 0010 z=~a
  - 0011 z=~b
  - 0100 {cy,z}=a+b, (WIDTH+1)-bit sum
  - 0101 {cy,z}=a+b+ci, where ci = cy flag (EXT_CY=0) or latched cy_in (EXT_CY=1)
  - 0110 z=a|b
  - 0111 z=a&b
  - 1000 z=0
  - 1001 z=1, zero-extended
  - 1010 z=all ones
  - 1011 cy=0
  - 1100 cy=1
  - 1101 {cy,z}=a+~b+1; cy=1 means no borrow (a>=b unsigned)
  - 1110 logical shift left a by b[SW-1:0]; cy = last bit shifted out of MSB
  - 1111 logical shift right a by b[SW-1:0]; cy = last bit shifted out of LSB
- Arithmetic wraps modulo 2^WIDTH; the overflow bit goes only to cy.
- During SHIFT, z shows the intermediate value each cycle. Consumers must wait for done.
- zf tracks the final z. For 1011/1100, zf is unchanged because z is unchanged.
- done is high for exactly one cycle per accepted start and is never asserted together with reset.
- No default case is left undefined: all 16 codes are decoded.

Test Plan (WIDTH=16, EXT_CY=0):
- Reset, then ADD a=FFFF b=0001 -> one cycle later z=0000, cy_out=1, zf=1, done pulse. Then ADC a=0001 b=0001 -> z=0003, cy_out=0.
- SUB a=0005 b=0007 -> z=FFFE, cy_out=0. SUB a=0007 b=0005 -> z=0002, cy_out=1, zf=0.
- SHL a=8001 b=0004 -> busy 5 cycles, z=0010, cy_out=0. SHR a=0001 b=0001 -> busy 2 cycles, z=0000, cy_out=1, zf=1.
- Start SHL a=00FF b=000F, then assert start with aluc=1000 on cycles 2-4 -> second start ignored; done after 16 cycles with z=8000, cy_out=1.
- Reset asserted on cycle 3 of a 10-cycle shift -> next cycle z=0, cy_out=0, zf=1, busy=0, no done pulse. A following start with aluc=1001 -> z=0001.
- 1100 then 1011 with a=1234 -> z holds its prior value, cy_out goes 1 then 0. Shift with b=0000 -> z=a, cy unchanged, 1-cycle latency.
